// File: rtl/i2c_reg_master.sv
// i2c_reg_master: single-master I2C write engine.
// Sends {addr,W}, register index and data byte as one open-drain transaction.
module i2c_reg_master #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h2A,
  parameter int         REGBITS     = 3,
  parameter int         QDIV        = 5,
  parameter int         STRETCH_MAX = 1000
) (
  input  logic               clk1d,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [REGBITS-1:0] cmd_reg,
  input  logic [7:0]         cmd_data,
  output logic               busy,
  output logic               done,
  output logic               nack,
  output logic               timeout,
  output logic               scl_oe,
  input  logic               scl_in,
  output logic               sda_oe,
  input  logic               sda_in
);
  localparam int QW = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam int SW = $clog2(STRETCH_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE, S_START, S_BIT, S_STOP
  } state_t;

  state_t          r_st;
  logic [QW-1:0]   r_qcnt;
  logic [1:0]      r_q;
  logic [4:0]      r_bit;
  logic [26:0]     r_sh;
  logic [SW-1:0]   r_str;
  logic            r_nk;

  logic w_qend;
  logic w_wait;
  logic w_hold;
  logic w_tick;
  logic w_abort;
  logic w_ackb;

  assign w_qend  = (r_qcnt == QW'(QDIV - 1));
  // SCL released by us but still low: slave is stretching
  assign w_wait  = ((r_st == S_BIT) && (r_q == 2'd2)) ||
                   ((r_st == S_STOP) && (r_q == 2'd1));
  assign w_hold  = w_wait && !scl_in;
  assign w_tick  = w_qend && !w_hold;
  assign w_abort = w_hold && (r_str == SW'(STRETCH_MAX - 1));
  assign w_ackb  = (r_bit == 5'd8) || (r_bit == 5'd17) ||
                   (r_bit == 5'd26);

  always_ff @(posedge clk1d or posedge rst) begin
    if (rst) begin
      r_st      <= S_IDLE;
      r_qcnt    <= '0;
      r_q       <= 2'd0;
      r_bit     <= 5'd0;
      r_sh      <= '0;
      r_str     <= '0;
      r_nk      <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      nack      <= 1'b0;
      timeout   <= 1'b0;
      scl_oe    <= 1'b0;
      sda_oe    <= 1'b0;
    end else begin
      done    <= 1'b0;
      nack    <= 1'b0;
      timeout <= 1'b0;
      r_str   <= w_hold ? r_str + 1'b1 : '0;
      if (!w_hold) r_qcnt <= w_qend ? '0 : r_qcnt + 1'b1;
      unique case (r_st)
        S_IDLE: begin
          if (cmd_valid) begin
            r_st      <= S_START;
            r_q       <= 2'd0;
            r_qcnt    <= '0;
            r_bit     <= 5'd0;
            r_nk      <= 1'b0;
            r_sh      <= {SLAVE_ADDR, 1'b0, 1'b1, 8'(cmd_reg),
                          1'b1, cmd_data, 1'b1};
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            scl_oe    <= 1'b0;
            sda_oe    <= 1'b1;
          end
        end
        S_START: begin
          if (w_tick) begin
            if (r_q == 2'd0) begin
              r_q <= 2'd1;
            end else begin
              r_st   <= S_BIT;
              r_q    <= 2'd0;
              scl_oe <= 1'b1;
              sda_oe <= ~r_sh[26];
            end
          end
        end
        S_BIT, S_STOP: begin
          if (w_abort) begin
            r_st      <= S_IDLE;
            scl_oe    <= 1'b0;
            sda_oe    <= 1'b0;
            done      <= 1'b1;
            nack      <= 1'b1;
            timeout   <= 1'b1;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end else if (w_tick && r_st == S_BIT) begin
            r_q <= r_q + 2'd1;
            if (r_q == 2'd1) scl_oe <= 1'b0;
            if (r_q == 2'd2 && w_ackb && sda_in) r_nk <= 1'b1;
            if (r_q == 2'd3) begin
              scl_oe <= 1'b1;
              // a missing ACK skips the remaining bytes
              if ((w_ackb && r_nk) || r_bit == 5'd26) begin
                r_st   <= S_STOP;
                r_q    <= 2'd0;
                sda_oe <= 1'b1;
              end else begin
                r_bit  <= r_bit + 5'd1;
                r_sh   <= r_sh << 1;
                sda_oe <= ~r_sh[25];
              end
            end
          end else if (w_tick) begin
            if (r_q == 2'd0) begin
              r_q    <= 2'd1;
              scl_oe <= 1'b0;
            end else if (r_q == 2'd1) begin
              r_q    <= 2'd2;
              sda_oe <= 1'b0;
            end else begin
              r_st      <= S_IDLE;
              r_q       <= 2'd0;
              done      <= 1'b1;
              nack      <= r_nk;
              busy      <= 1'b0;
              cmd_ready <= 1'b1;
            end
          end
        end
        default: r_st <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_reg_master.sv
// tb_i2c_reg_master: directed bench with an I2C slave decoder model.
// Checks latency, bus bytes, NACK, stretch, timeout, back-to-back, reset.
module tb_i2c_reg_master;
  logic       clk1d = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_reg;
  logic [7:0] cmd_data;
  logic       busy, done, nack, timeout;
  logic       scl_oe, sda_oe;
  logic       scl_w, sda_w;
  logic       slv_hold;
  logic       slv_present;
  int         tot = 0;
  int         bad = 0;

  logic       pscl = 1'b1;
  logic       psda = 1'b1;
  logic       s_low = 1'b0;
  logic       s_first = 1'b0;
  logic       s_addr = 1'b0;
  logic [7:0] s_sh = 8'h00;
  int         s_bc = 0;
  int         nstart = 0;
  int         nstop = 0;
  logic [7:0] rx_q[$];

  assign scl_w = ~(scl_oe | slv_hold);
  assign sda_w = ~(sda_oe | s_low);

  always #5 clk1d = ~clk1d;

  i2c_reg_master dut (
    .clk1d(clk1d), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_reg(cmd_reg), .cmd_data(cmd_data),
    .busy(busy), .done(done), .nack(nack), .timeout(timeout),
    .scl_oe(scl_oe), .scl_in(scl_w),
    .sda_oe(sda_oe), .sda_in(sda_w)
  );

  // slave: decodes START/STOP/bytes, ACKs address 0x54 when present
  always @(posedge clk1d) begin
    pscl <= scl_w;
    psda <= sda_w;
    if (pscl && scl_w && psda && !sda_w) begin
      nstart  <= nstart + 1;
      s_bc    <= 0;
      s_first <= 1'b1;
      s_low   <= 1'b0;
    end else if (pscl && scl_w && !psda && sda_w) begin
      nstop  <= nstop + 1;
      s_bc   <= 0;
      s_low  <= 1'b0;
      s_addr <= 1'b0;
    end else if (!pscl && scl_w) begin
      if (s_bc < 8) s_sh <= {s_sh[6:0], sda_w};
      s_bc <= s_bc + 1;
    end else if (pscl && !scl_w) begin
      if (s_bc == 8) begin
        rx_q.push_back(s_sh);
        if (s_first) begin
          s_addr  <= slv_present && (s_sh == 8'h54);
          s_low   <= slv_present && (s_sh == 8'h54);
          s_first <= 1'b0;
        end else begin
          s_low <= s_addr;
        end
      end else if (s_bc == 9) begin
        s_low <= 1'b0;
        s_bc  <= 0;
      end
    end
  end

  task automatic run_cmd(input logic [2:0] r, input logic [7:0] d,
                         input int sbit, input int slen,
                         output int lat, output logic o_nk,
                         output logic o_to, output logic o_oe,
                         output logic o_b1);
    int   rises;
    int   hc;
    logic pv;
    rises = 0; hc = 0; lat = 0;
    o_nk = 1'b0; o_to = 1'b0; o_oe = 1'b1; o_b1 = 1'b0;
    @(negedge clk1d);
    cmd_reg = r; cmd_data = d; cmd_valid = 1'b1;
    pv = scl_oe;
    do begin
      @(negedge clk1d);
      lat++;
      if (lat == 1) begin
        cmd_valid = 1'b0; cmd_reg = ~r; cmd_data = ~d;
        o_b1 = busy && !cmd_ready;
      end
      if (scl_oe && !pv) begin
        rises++;
        if (rises == sbit) slv_hold = 1'b1;
      end
      pv = scl_oe;
      if (slen > 0 && slv_hold && !scl_oe) begin
        hc++;
        if (hc == slen + 1) slv_hold = 1'b0;
      end
    end while (!done && lat < 3000);
    if (done) begin
      o_nk = nack; o_to = timeout; o_oe = scl_oe | sda_oe;
    end else begin
      lat = -1;
    end
    slv_hold = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_reg = '0; cmd_data = '0;
    slv_hold = 1'b0; slv_present = 1'b1;
    repeat (3) @(negedge clk1d);
    tot++; if (scl_oe !== 1'b0) begin bad++; $display("FAIL rst_scl_oe got=%b want=0", scl_oe); end
    tot++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL rst_sda_oe got=%b want=0", sda_oe); end
    tot++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    tot++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done); end
    tot++; if (nack !== 1'b0) begin bad++; $display("FAIL rst_nack got=%b want=0", nack); end
    tot++; if (timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout got=%b want=0", timeout); end
    tot++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", cmd_ready); end
    rst = 1'b0;
    repeat (2) @(negedge clk1d);
    tot++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL idle_ready got=%b want=1", cmd_ready); end
  endtask

  task automatic test_write(input string nm, input logic [2:0] r,
                            input logic [7:0] d, input int sbit,
                            input int slen, input int exp_lat);
    int         lat, base, s0, p0;
    logic       nk, to, oe, b1;
    logic [7:0] ex [3];
    ex[0] = 8'h54; ex[1] = 8'(r); ex[2] = d;
    base = rx_q.size(); s0 = nstart; p0 = nstop;
    run_cmd(r, d, sbit, slen, lat, nk, to, oe, b1);
    repeat (2) @(negedge clk1d);
    tot++; if (lat != exp_lat) begin bad++; $display("FAIL %s_latency got=%0d want=%0d", nm, lat, exp_lat); end
    tot++; if (b1 !== 1'b1) begin bad++; $display("FAIL %s_busy_next got=%b want=1", nm, b1); end
    tot++; if (nk !== 1'b0 || to !== 1'b0) begin bad++; $display("FAIL %s_flags got=%b%b want=00", nm, nk, to); end
    tot++; if (rx_q.size() - base != 3) begin bad++; $display("FAIL %s_nbytes got=%0d want=3", nm, rx_q.size() - base); end
    for (int i = 0; i < 3; i++) begin
      tot++;
      if (rx_q.size() > base + i && rx_q[base + i] !== ex[i]) begin
        bad++; $display("FAIL %s_byte%0d got=%h want=%h", nm, i, rx_q[base + i], ex[i]);
      end
    end
    tot++; if (nstart - s0 != 1 || nstop - p0 != 1) begin bad++; $display("FAIL %s_startstop got=%0d/%0d want=1/1", nm, nstart - s0, nstop - p0); end
  endtask

  task automatic test_nack();
    int   lat, base, p0;
    logic nk, to, oe, b1;
    slv_present = 1'b0;
    base = rx_q.size(); p0 = nstop;
    run_cmd(3'd0, 8'hA5, 0, 0, lat, nk, to, oe, b1);
    repeat (2) @(negedge clk1d);
    slv_present = 1'b1;
    tot++; if (lat != 206) begin bad++; $display("FAIL nack_latency got=%0d want=206", lat); end
    tot++; if (nk !== 1'b1 || to !== 1'b0) begin bad++; $display("FAIL nack_flags got=%b%b want=10", nk, to); end
    tot++; if (rx_q.size() - base != 1) begin bad++; $display("FAIL nack_nbytes got=%0d want=1", rx_q.size() - base); end
    tot++; if (rx_q.size() > base && rx_q[base] !== 8'h54) begin bad++; $display("FAIL nack_addr got=%h want=54", rx_q[base]); end
    tot++; if (nstop - p0 != 1) begin bad++; $display("FAIL nack_stop got=%0d want=1", nstop - p0); end
    tot++; if (nack !== 1'b0) begin bad++; $display("FAIL nack_after_done got=%b want=0", nack); end
  endtask

  task automatic test_timeout();
    int   lat;
    logic nk, to, oe, b1;
    slv_hold = 1'b1;
    run_cmd(3'd0, 8'h11, 0, 0, lat, nk, to, oe, b1);
    repeat (3) @(negedge clk1d);
    tot++; if (lat != 1021) begin bad++; $display("FAIL to_latency got=%0d want=1021", lat); end
    tot++; if (nk !== 1'b1 || to !== 1'b1) begin bad++; $display("FAIL to_flags got=%b%b want=11", nk, to); end
    tot++; if (oe !== 1'b0) begin bad++; $display("FAIL to_lines got=%b want=0", oe); end
    tot++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL to_idle got=%b%b want=10", cmd_ready, busy); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] dv [4];
    logic [7:0] ex [12];
    int         lat, k, base, s0;
    dv[0] = 8'h68; dv[1] = 8'h02; dv[2] = 8'h00; dv[3] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      ex[3*i] = 8'h54; ex[3*i+1] = 8'(i); ex[3*i+2] = dv[i];
    end
    base = rx_q.size(); s0 = nstart;
    @(negedge clk1d);
    cmd_valid = 1'b1; cmd_reg = 3'd0; cmd_data = dv[0];
    k = 0; lat = 0;
    while (k < 4 && lat < 3000) begin
      @(negedge clk1d);
      lat++;
      if (lat == 1) begin
        tot++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy%0d got=%b want=1", k, busy); end
        if (k < 3) begin
          cmd_reg = 3'(k + 1); cmd_data = dv[k + 1];
        end else begin
          cmd_valid = 1'b0;
        end
      end
      if (done) begin
        tot++; if (lat != 566) begin bad++; $display("FAIL b2b_latency%0d got=%0d want=566", k, lat); end
        tot++; if (cmd_ready !== 1'b1 || nack !== 1'b0) begin bad++; $display("FAIL b2b_ready%0d got=%b%b want=10", k, cmd_ready, nack); end
        k++; lat = 0;
      end
    end
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk1d);
    tot++; if (k != 4) begin bad++; $display("FAIL b2b_count got=%0d want=4", k); end
    tot++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_final_busy got=%b want=0", busy); end
    tot++; if (nstart - s0 != 4) begin bad++; $display("FAIL b2b_starts got=%0d want=4", nstart - s0); end
    tot++; if (rx_q.size() - base != 12) begin bad++; $display("FAIL b2b_nbytes got=%0d want=12", rx_q.size() - base); end
    for (int i = 0; i < 12; i++) begin
      tot++;
      if (rx_q.size() > base + i && rx_q[base + i] !== ex[i]) begin
        bad++; $display("FAIL b2b_byte%0d got=%h want=%h", i, rx_q[base + i], ex[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk1d);
    cmd_reg = 3'd1; cmd_data = 8'h3C; cmd_valid = 1'b1;
    @(negedge clk1d);
    cmd_valid = 1'b0;
    // second data bit (0) of byte 0x3C: SCL low phase, SDA low
    repeat (397) @(negedge clk1d);
    tot++; if (scl_oe !== 1'b1 || sda_oe !== 1'b1) begin bad++; $display("FAIL mid_lines got=%b%b want=11", scl_oe, sda_oe); end
    #2 rst = 1'b1;
    #1;
    tot++; if (scl_oe !== 1'b0 || sda_oe !== 1'b0) begin bad++; $display("FAIL async_release got=%b%b want=00", scl_oe, sda_oe); end
    @(negedge clk1d);
    rst = 1'b0;
    @(negedge clk1d);
    tot++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL after_rst got=%b%b want=01", busy, cmd_ready); end
    test_write("post_rst", 3'd2, 8'h5A, 0, 0, 566);
  endtask

  initial begin
    test_reset();
    test_write("basic", 3'd0, 8'hA5, 0, 0, 566);
    test_nack();
    test_write("stretch", 3'd0, 8'hA5, 22, 40, 606);
    test_timeout();
    repeat (5) @(negedge clk1d);
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
